// File: rtl/apb_bridge_pkg.sv
// Shared types and helpers for the APB memory bridge and related APB peripherals.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    ISSUE   = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam int unsigned ERR_CNT_W = 8;

  // Bank index is the part of the APB address above the in-bank word address.
  function automatic int unsigned bank_of(input logic [31:0] paddr, input int unsigned bank_aw);
    return int'(paddr >> bank_aw);
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Loadable down-counter with a registered zero flag; stops at zero.
module apb_wait_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      value <= load_val;
      zero  <= (load_val == '0);
    end else if (dec && !zero) begin
      value <= value - W'(1);
      zero  <= (value == W'(1));
    end
  end

endmodule

// File: rtl/apb_mem_bridge.sv
// APB slave bridging each transfer onto one of NUM_BANKS memory channels,
// with programmable wait states, unmapped-address errors and abort handling.
module apb_mem_bridge
  import apb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned BANK_AW   = 6,
  parameter int unsigned MAX_WAIT  = 15,
  parameter int unsigned WAIT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        psel,
  input  logic                        penable,
  input  logic                        pwrite,
  input  logic [ADDR_W-1:0]           paddr,
  input  logic [DATA_W-1:0]           pwdata,
  input  logic [WAIT_W-1:0]           wait_cfg,
  output logic [DATA_W-1:0]           prdata,
  output logic                        pready,
  output logic                        pslverr,
  output logic [NUM_BANKS-1:0]        mem_wren,
  output logic [NUM_BANKS-1:0]        mem_rden,
  output logic [BANK_AW-1:0]          mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [NUM_BANKS*DATA_W-1:0] mem_rdata,
  output logic [ERR_CNT_W-1:0]        err_cnt
);

  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  state_t              state, state_n;
  logic                wr_q, bad_q;
  logic [BANK_AW-1:0]  addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BANK_W-1:0]   bank_q;

  logic                setup, dec, cnt_zero, bad_c;
  logic [WAIT_W-1:0]   load_val, cnt_val;
  int unsigned         bank_c;
  logic [DATA_W-1:0]   rdata_sel;

  logic [DATA_W-1:0]    prdata_n, mem_wdata_n;
  logic                 pready_n, pslverr_n;
  logic [NUM_BANKS-1:0] wren_n, rden_n;
  logic [BANK_AW-1:0]   mem_addr_n;
  logic [ERR_CNT_W-1:0] err_cnt_n;

  assign setup    = (state == IDLE) && psel && !penable;
  assign load_val = (32'(wait_cfg) > MAX_WAIT) ? WAIT_W'(MAX_WAIT) : wait_cfg;
  assign bank_c   = bank_of(32'(paddr), BANK_AW);
  assign bad_c    = (bank_c >= NUM_BANKS);

  apb_wait_counter #(.W(WAIT_W)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (setup),
    .load_val (load_val),
    .dec      (dec),
    .value    (cnt_val),
    .zero     (cnt_zero)
  );

  // Read-data mux over the per-bank return buses.
  always_comb begin
    rdata_sel = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (32'(bank_q) == b) rdata_sel = mem_rdata[b*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_n     = state;
    dec         = 1'b0;
    prdata_n    = '0;
    pready_n    = 1'b0;
    pslverr_n   = 1'b0;
    wren_n      = '0;
    rden_n      = '0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    err_cnt_n   = err_cnt;

    case (state)
      IDLE:    if (setup) state_n = WAIT;
      WAIT: begin
        if (!psel)          state_n = IDLE;
        else if (!cnt_zero) dec = 1'b1;
        else if (bad_q)     state_n = RESP;
        else                state_n = ISSUE;
      end
      ISSUE:   state_n = !psel ? IDLE : (wr_q ? RESP : CAPTURE);
      CAPTURE: state_n = !psel ? IDLE : RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Outputs are computed for the state being entered so they appear registered in it.
    if (state_n == ISSUE) begin
      if (wr_q) wren_n = NUM_BANKS'(1) << bank_q;
      else      rden_n = NUM_BANKS'(1) << bank_q;
      mem_addr_n  = addr_q;
      mem_wdata_n = wdata_q;
    end
    if (state == CAPTURE && state_n == RESP) prdata_n = rdata_sel;
    if (state_n == RESP) begin
      pready_n  = 1'b1;
      pslverr_n = bad_q;
      if (bad_q && err_cnt != '1) err_cnt_n = err_cnt + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      mem_wren  <= '0;
      mem_rden  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err_cnt   <= '0;
      wr_q      <= 1'b0;
      bad_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bank_q    <= '0;
    end else begin
      state     <= state_n;
      prdata    <= prdata_n;
      pready    <= pready_n;
      pslverr   <= pslverr_n;
      mem_wren  <= wren_n;
      mem_rden  <= rden_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      err_cnt   <= err_cnt_n;
      if (setup) begin
        wr_q    <= pwrite;
        addr_q  <= paddr[BANK_AW-1:0];
        wdata_q <= pwdata;
        bank_q  <= BANK_W'(bank_c);
        bad_q   <= bad_c;
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Self-checking bench for apb_mem_bridge: directed table, hand-written corner
// sequences and randomized transfers against a flat-address reference model.
module tb_apb_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  wait_cfg;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [1:0]  mem_wren, mem_rden;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic [7:0]  err_cnt;

  apb_mem_bridge dut (
    .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .wait_cfg(wait_cfg), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .mem_wren(mem_wren), .mem_rden(mem_rden),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] init_word(input int a);
    return (a == 'h45) ? 32'h12345678 : {16'hC0DE, 8'(a), 8'h5A};
  endfunction

  // Bank memories seen by the DUT: registered read, one cycle after rden.
  logic        mem_fill;
  logic [31:0] mem [0:1][0:63];
  logic [31:0] rd  [0:1];
  assign mem_rdata = {rd[1], rd[0]};
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (mem_fill) begin
        for (int i = 0; i < 64; i++) mem[b][i] <= init_word(b*64 + i);
      end else begin
        if (mem_wren[b]) mem[b][mem_addr] <= mem_wdata;
        if (mem_rden[b]) rd[b] <= mem[b][mem_addr];
      end
    end
  end

  // Reference model: flat address space of 128 words plus a saturating error count.
  logic [31:0] shadow [0:127];
  int          err_model = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (pslverr) check("pslverr_without_pready", 32'(pready), 32'd1);
      if ((mem_wren | mem_rden) != 2'b00)
        check("strobe_onehot", 32'($countones({mem_wren, mem_rden})), 32'd1);
    end
  end

  int          r_cycle, r_scyc, r_nstrobe, r_abs;
  logic [31:0] r_prdata, r_mwdata;
  logic        r_err;
  logic [1:0]  r_wren, r_rden;
  logic [5:0]  r_maddr;

  // One APB transfer; entered and left just after a rising edge.
  task automatic do_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d, input int w);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; wait_cfg = 4'(w);
    r_cycle = -1; r_scyc = -1; r_nstrobe = 0; r_abs = 0; r_prdata = '0; r_err = 1'b0;
    r_wren = '0; r_rden = '0; r_maddr = '0; r_mwdata = '0;
    @(posedge clk); #1 penable = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if ((mem_wren | mem_rden) != 2'b00) begin
        r_nstrobe++; r_scyc = c; r_wren = mem_wren; r_rden = mem_rden;
        r_maddr = mem_addr; r_mwdata = mem_wdata;
      end
      if (pready) begin
        r_cycle = c; r_prdata = prdata; r_err = pslverr; r_abs = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic check_xfer(input string n, input int ecyc, input logic [31:0] eprd, input logic eerr,
                            input logic [1:0] ews, input logic [1:0] ers, input int escyc,
                            input logic [5:0] emaddr, input logic [31:0] ewdata);
    check({n, "_pready_cycle"}, 32'(r_cycle), 32'(ecyc));
    check({n, "_prdata"}, r_prdata, eprd);
    check({n, "_pslverr"}, 32'(r_err), 32'(eerr));
    check({n, "_strobe_count"}, 32'(r_nstrobe), ((ews | ers) != 2'b00) ? 32'd1 : 32'd0);
    if ((ews | ers) != 2'b00) begin
      check({n, "_strobe_cycle"}, 32'(r_scyc), 32'(escyc));
      check({n, "_wren"}, 32'(r_wren), 32'(ews));
      check({n, "_rden"}, 32'(r_rden), 32'(ers));
      check({n, "_mem_addr"}, 32'(r_maddr), 32'(emaddr));
      if (ews != 2'b00) check({n, "_mem_wdata"}, r_mwdata, ewdata);
    end
  endtask

  task automatic model_update(input logic wr, input logic [7:0] a, input logic [31:0] d);
    if (a >= 8'd128) err_model = (err_model == 255) ? 255 : err_model + 1;
    else if (wr) shadow[a[6:0]] = d;
  endtask

  task automatic run_model(input string n, input logic wr, input logic [7:0] a,
                           input logic [31:0] d, input int w);
    logic        bad;
    logic [1:0]  es;
    logic [31:0] eprd;
    int          ecyc;
    bad  = (a >= 8'd128);
    ecyc = bad ? w + 2 : (wr ? w + 3 : w + 4);
    eprd = (bad || wr) ? 32'd0 : shadow[a[6:0]];
    es   = bad ? 2'b00 : 2'(1 << (a / 64));
    do_xfer(wr, a, d, w);
    check_xfer(n, ecyc, eprd, bad, wr ? es : 2'b00, wr ? 2'b00 : es, w + 2, 6'(a % 64), d);
    model_update(wr, a, d);
    check({n, "_err_cnt"}, 32'(err_cnt), 32'(err_model));
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  a;
    logic [31:0] d;
    int          w;
    int          cyc;
    logic [31:0] prd;
    logic        err;
    logic [1:0]  wrs;
    logic [1:0]  rds;
    int          scyc;
    logic [5:0]  maddr;
  } vec_t;

  vec_t tbl [0:7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int seen, abs1;
    logic wr;
    logic [7:0] a;

    tbl[0] = '{1'b1, 8'h05, 32'hDEADBEEF,  0,  3, 32'h0,        1'b0, 2'b01, 2'b00, 2, 6'h05};
    tbl[1] = '{1'b0, 8'h45, 32'h0,         3,  7, 32'h12345678, 1'b0, 2'b00, 2'b10, 5, 6'h05};
    tbl[2] = '{1'b0, 8'h85, 32'h0,         1,  3, 32'h0,        1'b1, 2'b00, 2'b00, 0, 6'h00};
    tbl[3] = '{1'b0, 8'h05, 32'h0,         2,  6, 32'hDEADBEEF, 1'b0, 2'b00, 2'b01, 4, 6'h05};
    tbl[4] = '{1'b1, 8'hFF, 32'hCAFEF00D, 15, 17, 32'h0,        1'b1, 2'b00, 2'b00, 0, 6'h00};
    tbl[5] = '{1'b1, 8'h7F, 32'h0BADF00D,  7, 10, 32'h0,        1'b0, 2'b10, 2'b00, 9, 6'h3F};
    tbl[6] = '{1'b0, 8'h7F, 32'h0,         0,  4, 32'h0BADF00D, 1'b0, 2'b00, 2'b10, 2, 6'h3F};
    tbl[7] = '{1'b1, 8'h40, 32'h11112222,  1,  4, 32'h0,        1'b0, 2'b10, 2'b00, 3, 6'h00};
    for (int i = 0; i < 128; i++) shadow[i] = init_word(i);

    reset = 1'b1; mem_fill = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; wait_cfg = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_prdata", prdata, 32'd0);
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_wren", 32'(mem_wren), 32'd0);
    check("rst_rden", 32'(mem_rden), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1 reset = 1'b0; mem_fill = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_xfer(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].w);
      check_xfer($sformatf("tbl%0d", i), tbl[i].cyc, tbl[i].prd, tbl[i].err, tbl[i].wrs,
                 tbl[i].rds, tbl[i].scyc, tbl[i].maddr, tbl[i].d);
      model_update(tbl[i].wr, tbl[i].a, tbl[i].d);
    end
    check("tbl_err_cnt", 32'(err_cnt), 32'd2);

    // Abort: psel drops in the third wait cycle of a W=5 write.
    seen = 0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'hBAD0BAD0; wait_cfg = 4'd5;
    @(posedge clk); #1 penable = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (pready || mem_wren != 2'b00 || mem_rden != 2'b00) seen++;
      @(posedge clk); #1;
      if (c == 2) begin psel = 1'b0; penable = 1'b0; end
    end
    check("abort_no_activity", 32'(seen), 32'd0);
    check("abort_err_cnt", 32'(err_cnt), 32'(err_model));
    run_model("after_abort_wr", 1'b1, 8'h11, 32'h5555AAAA, 0);
    run_model("after_abort_rd", 1'b0, 8'h10, 32'h0, 1);

    // Randomized transfers, mostly mapped, with occasional idle gaps.
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
      run_model($sformatf("rnd%0d", i), wr, a, $urandom, int'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Back-to-back writes to both banks, no idle cycle in between.
    run_model("b2b_wr0", 1'b1, 8'h01, 32'hA0A0A0A0, 0);
    abs1 = r_abs;
    run_model("b2b_wr1", 1'b1, 8'h41, 32'hB1B1B1B1, 0);
    check("b2b_gap", 32'(r_abs - abs1), 32'd4);
    run_model("b2b_rd0", 1'b0, 8'h01, 32'h0, 0);
    run_model("b2b_rd1", 1'b0, 8'h41, 32'h0, 0);

    // Reset asserted while the read sits in CAPTURE.
    check("pre_reset_err_nonzero", 32'(err_cnt != 8'd0), 32'd1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h45; wait_cfg = 4'd0;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_prdata", prdata, 32'd0);
    check("midrst_pready", 32'(pready), 32'd0);
    check("midrst_pslverr", 32'(pslverr), 32'd0);
    check("midrst_strobes", 32'({mem_wren, mem_rden}), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    check("midrst_mem_wdata", mem_wdata, 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    reset = 1'b0; psel = 1'b0; penable = 1'b0; err_model = 0;
    @(posedge clk); #1;
    run_model("post_rst_rd", 1'b0, 8'h45, 32'h0, 2);

    // Error counter saturation.
    for (int i = 0; i < 260; i++) begin
      run_model($sformatf("sat%0d", i), 1'($urandom_range(0, 1)), 8'($urandom_range(128, 255)),
                $urandom, 0);
    end
    check("sat_err_cnt", 32'(err_cnt), 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_mem_bridge.md
Name: apb_mem_bridge

Overview:
- Parametrised APB slave that bridges APB transfers onto NUM_BANKS independent memory-bus channels.
- Successor to the single-channel APB slave. Adds configurable data/address width, multi-bank address decode, and per-transfer programmable wait states.
- Adds PSLVERR on unmapped addresses, abort handling, and a saturating error counter.
- Sits between the APB master (bus side) and the bank memories / I2C register blocks.

Parameters:
- ADDR_W, 8, APB address width. Must be > BANK_AW.
- DATA_W, 32, APB and memory data width.
- NUM_BANKS, 2, number of memory channels, 1..2**(ADDR_W-BANK_AW).
- BANK_AW, 6, word address width inside one bank.
- MAX_WAIT, 15, largest legal wait_cfg value.
- WAIT_W, $clog2(MAX_WAIT+1), width of the wait_cfg port.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  1=write, 0=read.
- paddr  in  ADDR_W  APB address.
- pwdata  in  DATA_W  write data.
- wait_cfg  in  WAIT_W  extra wait cycles; sampled at the setup edge.
- prdata  out  DATA_W  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  error response; valid only while pready=1.
- mem_wren  out  NUM_BANKS  one-hot write strobe.
- mem_rden  out  NUM_BANKS  one-hot read strobe.
- mem_addr  out  BANK_AW  bank word address.
- mem_wdata  out  DATA_W  write data to the bank.
- mem_rdata  in  NUM_BANKS*DATA_W  per-bank read data, valid the cycle after rden.
- err_cnt  out  8  saturating count of pslverr responses.

Behaviour:
- Reset: state=IDLE. prdata=0, pready=0, pslverr=0, mem_wren=0, mem_rden=0, mem_addr=0, mem_wdata=0, err_cnt=0.
- Reset asserted mid-transfer aborts it immediately; no strobe is issued after the reset edge.
- All outputs are registered.
- States: IDLE, WAIT, ISSUE, CAPTURE, RESP.
- IDLE:
  - Setup edge is psel=1 & penable=0.
  - On the setup edge, latch pwrite, paddr, pwdata; load cnt=min(wait_cfg,MAX_WAIT).
  - Decode bank = paddr>>BANK_AW; set bad = (bank >= NUM_BANKS).
  - Next state is WAIT.
- WAIT:
  - If cnt≠0: decrement cnt and stay.
  - If cnt=0: go to RESP when bad=1, else to ISSUE.
- ISSUE: exactly one cycle.
  - mem_wren[bank] or mem_rden[bank] = 1.
  - mem_addr = paddr[BANK_AW-1:0]; mem_wdata = latched pwdata.
  - Next state: write→RESP, read→CAPTURE.
- CAPTURE: prdata <= mem_rdata[bank*DATA_W +: DATA_W]; next state RESP.
- RESP: exactly one cycle, pready=1, then IDLE.
  - pslverr = bad.
  - err_cnt increments when bad=1 and saturates at 255.
  - On a bad read or on a write, prdata is 0 in RESP.
- Latency, counted in access cycles with cycle 1 = first penable cycle:
  - Write: pready in cycle W+3.
  - Read: pready in cycle W+4.
  - Bad address: pready in cycle W+2.
- pready is 0 in every cycle other than RESP. pslverr is 0 whenever pready=0.
- Back-to-back: a setup edge in the cycle after RESP is accepted with no gap.
- Abort: if psel=0 in any WAIT/ISSUE/CAPTURE cycle, return to IDLE next edge.
  - No strobe is issued if abort precedes ISSUE.
  - pready is never asserted for an aborted transfer; err_cnt is unchanged.
- Setup edge seen outside IDLE is ignored.
- Strobes are never asserted on more than one bank, and never both wren and rden.

Decomposition:
- Package apb_bridge_pkg holds:
  - state_t enum {IDLE, WAIT, ISSUE, CAPTURE, RESP};
  - the ERR_CNT_W=8 constant;
  - function bank_of(paddr).
- One sub-module, apb_wait_counter: loadable down-counter with load, value, and zero flag outputs, reused by future APB peripherals.

Test Plan:
- Write, W=0, paddr=0x05, pwdata=0xDEADBEEF:
  - mem_wren=2'b01 and mem_addr=5 in access cycle 2;
  - pready=1, pslverr=0 in cycle 3.
- Read, W=3, paddr=0x45, mem_rdata bank1=0x12345678:
  - mem_rden=2'b10 in cycle 5;
  - pready=1 in cycle 7 with prdata=0x12345678.
- Unmapped, paddr=0x85, W=1:
  - no strobe asserted;
  - pready=1, pslverr=1 in cycle 3; err_cnt=1.
- Abort: psel dropped in WAIT with W=5 → no strobe, no pready, state IDLE; then a normal write completes correctly.
- Reset mid-transfer: reset asserted during CAPTURE → all outputs 0 next cycle, err_cnt=0.
- 260 unmapped transfers → err_cnt saturates at 255; back-to-back writes to both banks complete with zero idle cycles between them.
